// File: rtl/me_best_match_if.sv
// ---------------------------------------------------------------------------
// me_best_match_if
// Bundles the signals between the SAD array, the best-match stage and the
// mode-decision stage.
//   start      : begin a new macroblock search (upstream -> stage)
//   ready      : stage is idle and will accept start (stage -> upstream)
//   sad_valid  : sad_in carries the next candidate SAD (upstream -> stage)
//   sad_in     : candidate SAD, unsigned
//   out_valid  : result available, held until accepted (stage -> downstream)
//   out_ready  : downstream accepts the result (downstream -> stage)
//   best_sad   : minimum SAD of the finished search
//   mv_x, mv_y : signed motion vector of the best candidate
// The master modport is the side driving the stage's inputs; the slave
// modport is the best-match stage itself.
// ---------------------------------------------------------------------------
interface me_best_match_if #(
   parameter int SAD_W = 16,
   parameter int MV_W  = 6
);
   logic             start;
   logic             ready;
   logic             sad_valid;
   logic [SAD_W-1:0] sad_in;
   logic             out_valid;
   logic             out_ready;
   logic [SAD_W-1:0] best_sad;
   logic [MV_W-1:0]  mv_x;
   logic [MV_W-1:0]  mv_y;

   modport master (
      output start, sad_valid, sad_in, out_ready,
      input  ready, out_valid, best_sad, mv_x, mv_y
   );

   modport slave (
      input  start, sad_valid, sad_in, out_ready,
      output ready, out_valid, best_sad, mv_x, mv_y
   );
endinterface

// File: rtl/me_best_match.sv
// ---------------------------------------------------------------------------
// me_best_match
// Scans one SAD per candidate position (raster order, column fastest) over
// the search window, keeps the smallest SAD and the position that produced
// it, and hands the best SAD plus a signed motion vector downstream through
// a valid/ready handshake.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : me_best_match_if.slave (start/ready, sad_valid/sad_in,
//         out_valid/out_ready, best_sad, mv_x, mv_y)
// ---------------------------------------------------------------------------
module me_best_match #(
   parameter int MACRO_DIM  = 16,
   parameter int SEARCH_DIM = 48,
   parameter int SAD_W      = 16,
   parameter int MV_W       = 6
) (
   input logic            clk,
   input logic            rst,
   me_best_match_if.slave bus
);

   localparam int NPOS = SEARCH_DIM - MACRO_DIM + 1;
   localparam int OFS  = (SEARCH_DIM - MACRO_DIM) / 2;
   localparam logic [5:0] LAST_POS = 6'(NPOS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [5:0]       col_q, col_d;
   logic [5:0]       row_q, row_d;
   logic [SAD_W-1:0] min_sad_q, min_sad_d;
   logic [5:0]       best_col_q, best_col_d;
   logic [5:0]       best_row_q, best_row_d;
   logic             first_q, first_d;
   logic             ready_q, ready_d;
   logic             out_valid_q, out_valid_d;
   logic [SAD_W-1:0] best_sad_q, best_sad_d;
   logic [MV_W-1:0]  mv_x_q, mv_x_d;
   logic [MV_W-1:0]  mv_y_q, mv_y_d;
   logic             take_sad;

   // Strict less-than keeps the earliest candidate on ties; the first
   // candidate of a search is always taken so an all-ones SAD still wins.
   assign take_sad = first_q || (bus.sad_in < min_sad_q);

   // Next-state logic. The result registers are loaded on the same edge that
   // accepts the last candidate, so the final compare is folded in through
   // the *_d values rather than the registered minimum.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      min_sad_d   = min_sad_q;
      best_col_d  = best_col_q;
      best_row_d  = best_row_q;
      first_d     = first_q;
      ready_d     = ready_q;
      out_valid_d = out_valid_q;
      best_sad_d  = best_sad_q;
      mv_x_d      = mv_x_q;
      mv_y_d      = mv_y_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               col_d     = '0;
               row_d     = '0;
               first_d   = 1'b1;
               min_sad_d = '1;
               ready_d   = 1'b0;
               state_d   = SEARCH;
            end
         end

         SEARCH: begin
            if (bus.sad_valid) begin
               first_d = 1'b0;
               if (take_sad) begin
                  min_sad_d  = bus.sad_in;
                  best_col_d = col_q;
                  best_row_d = row_q;
               end
               if (col_q == LAST_POS) begin
                  col_d = '0;
                  if (row_q == LAST_POS) begin
                     row_d       = '0;
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                     best_sad_d  = min_sad_d;
                     mv_x_d      = MV_W'(best_col_d) - MV_W'(OFS);
                     mv_y_d      = MV_W'(best_row_d) - MV_W'(OFS);
                  end else begin
                     row_d = row_q + 6'd1;
                  end
               end else begin
                  col_d = col_q + 6'd1;
               end
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               ready_d     = 1'b1;
            end
         end

         default: begin
            state_d     = IDLE;
            ready_d     = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         min_sad_q   <= '1;
         best_col_q  <= '0;
         best_row_q  <= '0;
         first_q     <= 1'b0;
         ready_q     <= 1'b1;
         out_valid_q <= 1'b0;
         best_sad_q  <= '0;
         mv_x_q      <= '0;
         mv_y_q      <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         min_sad_q   <= min_sad_d;
         best_col_q  <= best_col_d;
         best_row_q  <= best_row_d;
         first_q     <= first_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         best_sad_q  <= best_sad_d;
         mv_x_q      <= mv_x_d;
         mv_y_q      <= mv_y_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.best_sad  = best_sad_q;
   assign bus.mv_x      = mv_x_q;
   assign bus.mv_y      = mv_y_q;

endmodule

// File: tb/tb_me_best_match.sv
// ---------------------------------------------------------------------------
// tb_me_best_match
// Randomised bench for me_best_match. Each search draws a 33x33 table of
// SADs; a reference model picks the winner straight from the table and
// queues the expected result. A monitor pops the queue whenever the DUT's
// result is accepted and compares it.
// ---------------------------------------------------------------------------
module tb_me_best_match;

   localparam int NPOS  = 33;
   localparam int NCAND = NPOS * NPOS;
   localparam int OFS   = 16;

   typedef struct {
      int sad;
      int mvx;
      int mvy;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   me_best_match_if bus ();

   me_best_match dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   sads[NCAND];
   int   exp_sad;
   int   exp_mvx;
   int   exp_mvy;

   // One comparison: counts it and reports a mismatch on a single line.
   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // Reference: lowest SAD wins, earliest index in raster order on ties;
   // the index splits into row/col which are re-centred on the window.
   task automatic computeModel();
      int best;
      best = 0;
      for (int i = 1; i < NCAND; i++)
         if (sads[i] < sads[best]) best = i;
      exp_sad = sads[best];
      exp_mvx = (best % NPOS) - OFS;
      exp_mvy = (best / NPOS) - OFS;
   endtask

   task automatic fillConst(input int v);
      for (int i = 0; i < NCAND; i++) sads[i] = v;
   endtask

   task automatic fillRandom(input int lo, input int hi);
      for (int i = 0; i < NCAND; i++) sads[i] = int'($urandom_range(hi, lo));
   endtask

   // Inputs change one time unit after the rising edge, well clear of it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic startSearch();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checkOutput("ready_low_after_start", int'(bus.ready), 0);
   endtask

   // Presents `count` candidates from the table with optional random bubbles.
   task automatic feed(input int count, input int bubble_pct, output int early);
      early = 0;
      for (int i = 0; i < count; i++) begin
         while (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct) begin
            bus.sad_valid = 1'b0;
            bus.sad_in    = 16'($urandom);
            step();
            if (bus.out_valid) early = 1;
         end
         bus.sad_valid = 1'b1;
         bus.sad_in    = 16'(sads[i]);
         step();
         bus.sad_valid = 1'b0;
         if (i != NCAND - 1 && bus.out_valid) early = 1;
      end
   endtask

   // Full search: queue the expected result, then drive start and all SADs.
   task automatic applyStimulus(input int bubble_pct);
      exp_t e;
      int   early;
      computeModel();
      e.sad = exp_sad;
      e.mvx = exp_mvx;
      e.mvy = exp_mvy;
      exp_q.push_back(e);
      startSearch();
      feed(NCAND, bubble_pct, early);
      checkOutput("no_early_valid", early, 0);
      checkOutput("valid_latency", int'(bus.out_valid), 1);
   endtask

   task automatic acceptResult();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      checkOutput("ready_after_accept", int'(bus.ready), 1);
      checkOutput("valid_drop_after_accept", int'(bus.out_valid), 0);
   endtask

   // Monitor: compares the result on every accepted transfer.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("mon_best_sad", int'(bus.best_sad), e.sad);
            checkOutput("mon_mv_x", int'($signed(bus.mv_x)), e.mvx);
            checkOutput("mon_mv_y", int'($signed(bus.mv_y)), e.mvy);
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin : stimulus
      int early;

      // Reset held for two cycles while start and sad_valid are asserted.
      rst           = 1'b1;
      bus.start     = 1'b1;
      bus.sad_valid = 1'b1;
      bus.sad_in    = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      checkOutput("reset_ready", int'(bus.ready), 1);
      checkOutput("reset_out_valid", int'(bus.out_valid), 0);
      checkOutput("reset_best_sad", int'(bus.best_sad), 0);
      checkOutput("reset_mv_x", int'($signed(bus.mv_x)), 0);
      checkOutput("reset_mv_y", int'($signed(bus.mv_y)), 0);
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.sad_valid = 1'b0;
      step();

      // Single minimum at row 20, col 5.
      fillConst(1000);
      sads[20 * NPOS + 5] = 10;
      applyStimulus(0);
      acceptResult();

      // Tie: the earlier of two equal minima wins; start right after accept.
      fillConst(100);
      sads[3 * NPOS + 3]   = 50;
      sads[30 * NPOS + 30] = 50;
      applyStimulus(0);
      acceptResult();

      // All-ones everywhere: the very first candidate is kept.
      fillConst(16'hFFFF);
      applyStimulus(0);
      acceptResult();

      // Bubbles on sad_valid, minimum at the last candidate.
      fillRandom(200, 65535);
      sads[32 * NPOS + 32] = 0;
      applyStimulus(40);
      acceptResult();

      // Narrow random range so ties are frequent, with bubbles.
      fillRandom(0, 300);
      applyStimulus(25);
      acceptResult();

      // Backpressure: result must hold while start/sad_valid toggle.
      fillRandom(0, 500);
      applyStimulus(0);
      for (int c = 0; c < 10; c++) begin
         bus.start     = 1'($urandom_range(1));
         bus.sad_valid = 1'b1;
         bus.sad_in    = '0;
         step();
         checkOutput("hold_out_valid", int'(bus.out_valid), 1);
         checkOutput("hold_best_sad", int'(bus.best_sad), exp_sad);
         checkOutput("hold_mv_x", int'($signed(bus.mv_x)), exp_mvx);
         checkOutput("hold_mv_y", int'($signed(bus.mv_y)), exp_mvy);
      end
      bus.start     = 1'b0;
      bus.sad_valid = 1'b0;
      acceptResult();

      // Reset after 500 small SADs; the aborted run must leave no trace.
      fillRandom(0, 5);
      startSearch();
      feed(500, 20, early);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("midreset_ready", int'(bus.ready), 1);
      checkOutput("midreset_out_valid", int'(bus.out_valid), 0);
      checkOutput("midreset_best_sad", int'(bus.best_sad), 0);
      fillConst(1000);
      sads[16 * NPOS + 16] = 7;
      applyStimulus(0);
      acceptResult();

      step();
      step();
      checkOutput("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/me_best_match.md
Name: me_best_match

Overview:
- Motion-estimation stage directly downstream of the ME controller and SAD array.
- Consumes one 16x16 SAD per candidate position, in raster order across the search window, whenever upstream asserts valid.
- Tracks the minimum SAD and the candidate position that produced it.
- At the end of the window, presents the best SAD and a signed motion vector to the mode-decision stage through a valid/ready handshake.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search window edge in pixels.
- SAD_W, 16, SAD width; 16 bits is sufficient because 255*256 = 65280.
- MV_W, 6, signed motion-vector component width.
- Derived (not overridable): NPOS = SEARCH_DIM-MACRO_DIM+1 = 33 positions per axis; OFS = (SEARCH_DIM-MACRO_DIM)/2 = 16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a new macroblock search; sampled only in IDLE
- ready  out  1  high in IDLE only
- sad_valid  in  1  sad_in carries the SAD of the next candidate
- sad_in  in  SAD_W  candidate SAD, unsigned
- out_valid  out  1  result available; held until accepted
- out_ready  in  1  downstream accepts the result
- best_sad  out  SAD_W  minimum SAD found
- mv_x  out  MV_W  signed horizontal vector, range -16..+16
- mv_y  out  MV_W  signed vertical vector, range -16..+16

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE; ready=1; out_valid=0; best_sad=0; mv_x=0; mv_y=0; col=0; row=0. Reset dominates all other inputs in the same cycle.
- Internal registers:
  - col, row: 6-bit unsigned, 0..NPOS-1.
  - min_sad: SAD_W bits.
  - best_col, best_row: 6 bits each.
  - first: 1 bit.
- IDLE:
  - ready=1, out_valid=0.
  - start=1 -> col=0, row=0, first=1, min_sad=all-ones; go to SEARCH.
  - sad_valid is ignored.
- SEARCH:
  - ready=0, out_valid=0. start is ignored.
  - On each cycle with sad_valid=1:
    - If first=1 OR sad_in < min_sad (strict): min_sad<=sad_in, best_col<=col, best_row<=row.
    - first<=0.
    - Advance col. When col=NPOS-1: col<=0, row<=row+1.
  - Cycles with sad_valid=0 change nothing.
  - When sad_valid=1 with row=NPOS-1 and col=NPOS-1 (candidate 1089): perform the compare above, then go to DONE.
- Tie rule: strict less-than, so the earliest candidate in raster order (row-major, col fastest) wins.
- DONE:
  - out_valid=1.
  - best_sad=min_sad.
  - mv_x = best_col-OFS and mv_y = best_row-OFS, as two's complement MV_W bits.
  - Outputs are registered and stable for as long as out_valid=1.
  - out_ready=1 -> IDLE next cycle, and out_valid drops that same next cycle.
  - sad_valid and start are ignored.
- Latency: out_valid rises on the clock edge following the cycle in which the 1089th sad_valid is accepted.
- Outputs outside DONE:
  - best_sad, mv_x and mv_y hold their last DONE values (0 after reset).
  - Consumers qualify them with out_valid only.
- Back-to-back searches: start may be asserted in the first IDLE cycle after acceptance. Minimum gap from out_ready to the next search start is 1 cycle.
- Reset mid-operation (SEARCH or DONE): everything returns to reset values; any partial result is discarded. No residual state is carried into the next search.
- Arithmetic:
  - SAD compare is unsigned at SAD_W bits.
  - mv computation is 6-bit subtract; the range -16..+16 never overflows MV_W=6.
  - Counters never exceed NPOS-1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 and sad_valid=1 -> ready=1, out_valid=0, best_sad=0, mv_x=0, mv_y=0.
- Single minimum: start, then 1089 SADs all 1000 except row 20, col 5 = 10 -> one cycle after the last valid: out_valid=1, best_sad=10, mv_x=-11, mv_y=+4.
- Tie plus first-candidate rule:
  - SAD 50 at (3,3) and at (30,30), all others 100 -> mv=(-13,-13), best_sad=50.
  - Separate run with all SADs 0xFFFF -> mv=(-16,-16), best_sad=0xFFFF.
- Bubbles: sad_valid randomly deasserted about 40% of cycles, minimum 0 at (32,32) -> DONE only after exactly 1089 accepted SADs; mv=(+16,+16).
- Handshake backpressure: in DONE, hold out_ready=0 for 10 cycles while pulsing start and sad_valid -> outputs unchanged and out_valid held. Raise out_ready -> ready=1 next cycle; a new start is accepted.
- Reset mid-search: assert rst after 500 candidates, then run a full search with the minimum 7 at (16,16) -> best_sad=7, mv=(0,0); no influence from the aborted run.
